// File: rtl/stepper_ramp_driver.sv
// ============================================================================
// stepper_ramp_driver : step/dir pulse generator with a symmetric linear ramp
// Revision 1.0 - first release
// ============================================================================
`default_nettype none

module stepper_ramp_driver #(
    parameter int STEPS_W      = 16,
    parameter int PERIOD_W     = 16,
    parameter int POS_W        = 24,
    parameter int PULSE_CYCLES = 100,
    parameter int DIR_SETUP    = 50
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic                    start,
    input  logic                    dir_in,
    input  logic [STEPS_W-1:0]      steps,
    input  logic [PERIOD_W-1:0]     start_period,
    input  logic [PERIOD_W-1:0]     min_period,
    input  logic [PERIOD_W-1:0]     accel,
    input  logic                    abort,
    output logic                    dir_out,
    output logic                    step_out,
    output logic                    busy,
    output logic                    done,
    output logic                    aborted,
    output logic signed [POS_W-1:0] position
);

    localparam logic [PERIOD_W-1:0] PULSE_FLOOR = PERIOD_W'(PULSE_CYCLES + 1);
    localparam logic [PERIOD_W-1:0] PULSE_LAST  = PERIOD_W'(PULSE_CYCLES - 1);
    localparam logic [PERIOD_W-1:0] SETUP_LAST  = PERIOD_W'(DIR_SETUP - 1);
    localparam logic [PERIOD_W-1:0] P_ONE       = PERIOD_W'(1);
    localparam logic [STEPS_W-1:0]  S_ONE       = STEPS_W'(1);
    localparam logic [POS_W-1:0]    POS_ONE     = POS_W'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        HIGH  = 2'd2,
        LOW   = 2'd3
    } state_t;

    state_t              state;
    logic [STEPS_W-1:0]  remaining;
    logic [STEPS_W-1:0]  ramp;
    logic [PERIOD_W-1:0] period;
    logic [PERIOD_W-1:0] eff_min;
    logic [PERIOD_W-1:0] eff_start;
    logic [PERIOD_W-1:0] cnt;
    logic                abort_pend;

    logic [PERIOD_W-1:0] new_min;
    logic [PERIOD_W-1:0] new_start;
    logic [PERIOD_W:0]   period_up;
    logic [PERIOD_W-1:0] decel_period;
    logic [PERIOD_W-1:0] headroom;
    logic [PERIOD_W-1:0] accel_period;
    logic [PERIOD_W-1:0] low_last;
    logic                in_decel;

    // The period can never drop below one pulse plus one low cycle.
    assign new_min      = (min_period > PULSE_FLOOR) ? min_period : PULSE_FLOOR;
    assign new_start    = (start_period > new_min) ? start_period : new_min;
    assign period_up    = {1'b0, period} + {1'b0, accel};
    assign decel_period = (period_up > {1'b0, eff_start}) ? eff_start
                                                          : period_up[PERIOD_W-1:0];
    assign headroom     = period - eff_min;
    assign accel_period = (accel >= headroom) ? eff_min : (period - accel);
    assign low_last     = period - PULSE_FLOOR;
    // Slow down once the steps after the next one fit in the ramp already climbed,
    // which mirrors the acceleration profile step for step.
    assign in_decel     = ({1'b0, remaining} <= ({1'b0, ramp} + (STEPS_W+1)'(1)));

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            remaining  <= '0;
            ramp       <= '0;
            period     <= '0;
            eff_min    <= '0;
            eff_start  <= '0;
            cnt        <= '0;
            abort_pend <= 1'b0;
            dir_out    <= 1'b0;
            step_out   <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            aborted    <= 1'b0;
            position   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        aborted <= 1'b0;
                        if (steps != '0) begin
                            remaining  <= steps;
                            dir_out    <= dir_in;
                            period     <= new_start;
                            eff_min    <= new_min;
                            eff_start  <= new_start;
                            ramp       <= '0;
                            abort_pend <= 1'b0;
                            cnt        <= SETUP_LAST;
                            busy       <= 1'b1;
                            done       <= 1'b0;
                            state      <= SETUP;
                        end else begin
                            done <= 1'b1;
                        end
                    end
                end

                SETUP: begin
                    if (abort) begin
                        state   <= IDLE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        aborted <= 1'b1;
                    end else if (cnt == '0) begin
                        step_out  <= 1'b1;
                        remaining <= remaining - S_ONE;
                        position  <= dir_out ? (position + POS_ONE) : (position - POS_ONE);
                        cnt       <= PULSE_LAST;
                        state     <= HIGH;
                    end else begin
                        cnt <= cnt - P_ONE;
                    end
                end

                HIGH: begin
                    if (abort) begin
                        abort_pend <= 1'b1;
                    end
                    if (cnt == '0) begin
                        step_out <= 1'b0;
                        if (abort || abort_pend) begin
                            state   <= IDLE;
                            busy    <= 1'b0;
                            done    <= 1'b1;
                            aborted <= (remaining != '0);
                        end else begin
                            cnt   <= low_last;
                            state <= LOW;
                        end
                    end else begin
                        cnt <= cnt - P_ONE;
                    end
                end

                LOW: begin
                    if (abort) begin
                        state   <= IDLE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        aborted <= (remaining != '0);
                    end else if (cnt == '0) begin
                        if (in_decel) begin
                            period <= decel_period;
                            if (ramp != '0) begin
                                ramp <= ramp - S_ONE;
                            end
                        end else if (period > eff_min) begin
                            period <= accel_period;
                            ramp   <= ramp + S_ONE;
                        end
                        if (remaining == '0) begin
                            state   <= IDLE;
                            busy    <= 1'b0;
                            done    <= 1'b1;
                            aborted <= 1'b0;
                        end else begin
                            step_out  <= 1'b1;
                            remaining <= remaining - S_ONE;
                            position  <= dir_out ? (position + POS_ONE) : (position - POS_ONE);
                            cnt       <= PULSE_LAST;
                            state     <= HIGH;
                        end
                    end else begin
                        cnt <= cnt - P_ONE;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_stepper_ramp_driver.sv
// ============================================================================
// tb_stepper_ramp_driver : directed self-checking bench for stepper_ramp_driver
// Revision 1.0 - first release
// ============================================================================
`default_nettype none

module tb_stepper_ramp_driver;

    logic               clock = 1'b0;
    logic               reset_n = 1'b0;
    logic               start = 1'b0;
    logic               dir_in = 1'b0;
    logic [15:0]        steps = '0;
    logic [15:0]        start_period = '0;
    logic [15:0]        min_period = '0;
    logic [15:0]        accel = '0;
    logic               abort = 1'b0;
    logic               dir_out;
    logic               step_out;
    logic               busy;
    logic               done;
    logic               aborted;
    logic signed [23:0] position;

    stepper_ramp_driver #(
        .STEPS_W      (16),
        .PERIOD_W     (16),
        .POS_W        (24),
        .PULSE_CYCLES (2),
        .DIR_SETUP    (3)
    ) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .start        (start),
        .dir_in       (dir_in),
        .steps        (steps),
        .start_period (start_period),
        .min_period   (min_period),
        .accel        (accel),
        .abort        (abort),
        .dir_out      (dir_out),
        .step_out     (step_out),
        .busy         (busy),
        .done         (done),
        .aborted      (aborted),
        .position     (position)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int   rise_cyc[$];
    int   high_len[$];
    int   cur_len = 0;
    logic prev_step = 1'b0;
    int   busy_seen = 0;

    always @(negedge clock) begin
        if (step_out && !prev_step) rise_cyc.push_back(cyc);
        if (step_out) cur_len++;
        if (!step_out && prev_step) begin
            high_len.push_back(cur_len);
            cur_len = 0;
        end
        if (busy) busy_seen++;
        prev_step = step_out;
    end

    int n_checks = 0;
    int n_fail   = 0;
    int start_cyc;
    int done_cyc;

    task automatic check(input string tag, input logic signed [31:0] got,
                         input logic signed [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic clear_mon();
        rise_cyc.delete();
        high_len.delete();
        cur_len   = 0;
        busy_seen = 0;
    endtask

    task automatic launch(input logic d, input int n, input int sp, input int mp, input int ac);
        @(negedge clock);
        dir_in       = d;
        steps        = 16'(n);
        start_period = 16'(sp);
        min_period   = 16'(mp);
        accel        = 16'(ac);
        start        = 1'b1;
        start_cyc    = cyc;
        @(posedge clock);
        #1 start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int k;
        for (k = 0; k < budget; k++) begin
            @(negedge clock);
            if (done && !busy) break;
        end
        done_cyc = cyc;
        if (k == budget) check({tag, " timeout"}, 0, 1);
        #1;
    endtask

    task automatic wait_rises(input string tag, input int n, input int budget);
        int k;
        for (k = 0; k < budget; k++) begin
            @(negedge clock);
            #1;
            if (rise_cyc.size() >= n) break;
        end
        if (k == budget) check({tag, " rise timeout"}, 0, 1);
    endtask

    task automatic check_periods(input string tag, input int exp[]);
        check({tag, " pulses"}, rise_cyc.size(), exp.size());
        for (int i = 1; i < rise_cyc.size() && i < exp.size(); i++)
            check($sformatf("%s period%0d", tag, i), rise_cyc[i] - rise_cyc[i-1], exp[i-1]);
        if (rise_cyc.size() > 0)
            check({tag, " last period"}, done_cyc - rise_cyc[rise_cyc.size()-1], exp[exp.size()-1]);
        for (int i = 0; i < high_len.size(); i++)
            check($sformatf("%s high%0d", tag, i), high_len[i], 2);
    endtask

    initial begin
        int e_clamp[] = '{3, 3, 3, 3, 3};
        int e_flat[]  = '{10, 10, 10, 10};
        int e_ramp[]  = '{20, 15, 10, 15, 20, 20};

        repeat (3) @(negedge clock);
        check("rst step_out", step_out, 0);
        check("rst dir_out",  dir_out,  0);
        check("rst busy",     busy,     0);
        check("rst done",     done,     0);
        check("rst aborted",  aborted,  0);
        check("rst position", position, 0);
        reset_n = 1'b1;
        repeat (2) @(negedge clock);

        // Clamp: periods forced up to PULSE_CYCLES+1, negative direction
        clear_mon();
        launch(1'b0, 5, 2, 1, 1);
        check("clamp busy", busy, 1);
        wait_done("clamp", 200);
        check_periods("clamp", e_clamp);
        check("clamp first", rise_cyc.size() > 0 ? rise_cyc[0] - start_cyc : -1, 4);
        check("clamp position", position, -5);
        check("clamp dir_out", dir_out, 0);

        // Constant rate, positive direction
        clear_mon();
        launch(1'b1, 4, 10, 10, 0);
        wait_done("flat", 200);
        check_periods("flat", e_flat);
        check("flat first", rise_cyc.size() > 0 ? rise_cyc[0] - start_cyc : -1, 4);
        check("flat done", done, 1);
        check("flat aborted", aborted, 0);
        check("flat position", position, -1);
        check("flat dir_out", dir_out, 1);

        // Accelerate, cruise, decelerate
        clear_mon();
        launch(1'b1, 6, 20, 10, 5);
        check("ramp done cleared", done, 0);
        check("ramp busy", busy, 1);
        wait_done("ramp", 400);
        check_periods("ramp", e_ramp);
        check("ramp position", position, 5);

        // Abort in the HIGH phase of step 3 of 10
        clear_mon();
        launch(1'b1, 10, 10, 10, 0);
        wait_rises("abort", 3, 200);
        abort = 1'b1;
        @(posedge clock);
        #1 abort = 1'b0;
        wait_done("abort", 50);
        repeat (30) @(negedge clock);
        #1;
        check("abort pulses", rise_cyc.size(), 3);
        check("abort last high", high_len.size() >= 3 ? high_len[2] : -1, 2);
        check("abort aborted", aborted, 1);
        check("abort done", done, 1);
        check("abort busy", busy, 0);
        check("abort position", position, 8);

        // Zero-step move
        clear_mon();
        launch(1'b1, 0, 10, 10, 0);
        @(negedge clock);
        check("zero done", done, 1);
        check("zero aborted", aborted, 0);
        repeat (10) @(negedge clock);
        #1;
        check("zero busy_seen", busy_seen, 0);
        check("zero pulses", rise_cyc.size(), 0);
        check("zero position", position, 8);

        // Start while busy is ignored
        clear_mon();
        launch(1'b1, 3, 10, 10, 0);
        repeat (6) @(negedge clock);
        dir_in = 1'b0;
        steps  = 16'd5;
        start  = 1'b1;
        @(posedge clock);
        #1 start = 1'b0;
        wait_done("busy_start", 200);
        check("busy_start pulses", rise_cyc.size(), 3);
        check("busy_start dir_out", dir_out, 1);
        check("busy_start position", position, 11);

        // Asynchronous reset during HIGH
        clear_mon();
        launch(1'b1, 5, 10, 10, 0);
        wait_rises("async", 1, 100);
        check("async pre step_out", step_out, 1);
        reset_n = 1'b0;
        #1;
        check("async step_out", step_out, 0);
        check("async position", position, 0);
        check("async busy", busy, 0);
        check("async dir_out", dir_out, 0);
        @(negedge clock);
        reset_n = 1'b1;
        repeat (2) @(negedge clock);
        clear_mon();
        launch(1'b1, 2, 10, 10, 0);
        wait_done("post", 200);
        check("post pulses", rise_cyc.size(), 2);
        check("post first", rise_cyc.size() > 0 ? rise_cyc[0] - start_cyc : -1, 4);
        check("post position", position, 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
